ex_mem_skid: RTL

EX_MEM_SKID -- requirements
Module: ex_mem_skid

---
 rtl/ex_mem_skid_pkg.sv | 9 +
 rtl/ex_mem_skid_pipe_entry.sv | 33 +++
 rtl/ex_mem_skid.sv | 102 ++++++++++
 3 files changed

// File: rtl/ex_mem_skid_pkg.sv
// Shared constants for the pipeline registers: NOP register address,
// NOP memory op and the zero word used on idle payload lanes.
package ex_mem_skid_pkg;

    localparam int unsigned NOP_REG   = 0;
    localparam int unsigned NOP_MEMOP = 0;
    localparam int unsigned ZERO_WORD = 0;

endpackage

// File: rtl/ex_mem_skid_pipe_entry.sv
// One pipeline slot: a payload register with its own valid bit.
// Clear wins over load; reset zeroes both valid and payload.
module pipe_entry #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         ld_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o,
    output logic         vld_o
);

    logic [W-1:0] data_q;
    logic         vld_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else if (clr_i) begin
            vld_q  <= 1'b0;
        end else if (ld_i) begin
            vld_q  <= 1'b1;
            data_q <= d_i;
        end
    end

    assign q_o   = data_q;
    assign vld_o = vld_q;

endmodule

// File: rtl/ex_mem_skid.sv
// EX/MEM pipeline register with a skid slot, so ex_ready is purely
// registered while still sustaining one entry per cycle.
module ex_mem_skid
    import ex_mem_skid_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int OP_W   = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [ADDR_W-1:0] ex_wd,
    input  logic              ex_wreg,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic [OP_W-1:0]   ex_memop,
    input  logic [DATA_W-1:0] ex_maddr,
    input  logic [DATA_W-1:0] ex_sdata,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_wd,
    output logic              mem_wreg,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [OP_W-1:0]   mem_memop,
    output logic [DATA_W-1:0] mem_maddr,
    output logic [DATA_W-1:0] mem_sdata,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int PW = ADDR_W + 1 + OP_W + 3 * DATA_W;

    logic [PW-1:0]     ex_pl, out_pl, skid_pl, out_d;
    logic              out_vld, skid_vld;
    logic              accept, drain;
    logic              out_ld, out_clr, skid_ld, skid_clr;
    logic [CNT_W-1:0]  stall_q, stall_d;

    logic [ADDR_W-1:0] o_wd;
    logic              o_wreg;
    logic [DATA_W-1:0] o_wdata, o_maddr, o_sdata;
    logic [OP_W-1:0]   o_memop;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign ex_pl  = {ex_wd, ex_wreg, ex_wdata, ex_memop, ex_maddr, ex_sdata};
    assign accept = ex_valid && ex_ready;
    assign drain  = out_vld && mem_ready;

    // A held skid entry always has priority into OUT over fresh input.
    assign out_d    = skid_vld ? skid_pl : ex_pl;
    assign out_ld   = !flush && (!out_vld || drain) && (skid_vld || accept);
    assign out_clr  = flush || (drain && !skid_vld && !accept);
    assign skid_ld  = !flush && accept && out_vld && !drain;
    assign skid_clr = flush || (skid_vld && drain);

    pipe_entry #(.W(PW)) u_out (
        .clk   (clk),
        .rst   (rst),
        .clr_i (out_clr),
        .ld_i  (out_ld),
        .d_i   (out_d),
        .q_o   (out_pl),
        .vld_o (out_vld)
    );

    pipe_entry #(.W(PW)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .clr_i (skid_clr),
        .ld_i  (skid_ld),
        .d_i   (ex_pl),
        .q_o   (skid_pl),
        .vld_o (skid_vld)
    );

    assign stall_d = (out_vld && !mem_ready) ? sat_inc(stall_q) : stall_q;

    always_ff @(posedge clk) begin
        if (rst) stall_q <= '0;
        else     stall_q <= stall_d;
    end

    assign ex_ready  = !skid_vld;
    assign mem_valid = out_vld;
    assign stall_cnt = stall_q;

    assign {o_wd, o_wreg, o_wdata, o_memop, o_maddr, o_sdata} = out_pl;

    // Idle lanes read as a NOP so nothing downstream acts on stale data.
    assign mem_wd    = out_vld ? o_wd    : ADDR_W'(NOP_REG);
    assign mem_wreg  = out_vld && o_wreg;
    assign mem_wdata = out_vld ? o_wdata : DATA_W'(ZERO_WORD);
    assign mem_memop = out_vld ? o_memop : OP_W'(NOP_MEMOP);
    assign mem_maddr = out_vld ? o_maddr : DATA_W'(ZERO_WORD);
    assign mem_sdata = out_vld ? o_sdata : DATA_W'(ZERO_WORD);

endmodule
